iop_queue: RTL and testbench

//  Decoded-IOP buffer between instruction decode and the reservation station.

---
 rtl/iop_queue.sv | 72 +++++++
 tb/tb_iop_queue.sv | 125 ++++++++++++
 2 files changed

// File: rtl/iop_queue.sv
// iop_queue: decoded-IOP FIFO between instruction decode and the reservation station
// Optional build macro: IOPQ_BYPASS_EN adds an empty-queue dec_* -> id_* bypass.
// Ports:
//   clk, a_rst_n (async, active low), flush (sync discard of all entries)
//   dec_push/dec_iop/dec_init/dec_pc/dec_k16 : bundle offered by decode
//   dec_rdy (~full), dec_afull (count >= AFULL_LVL)
//   id_ack/id_iop/id_iop_init/id_pc/id_k16   : head bundle to the station
//   id_feed : station ready, pop = id_feed & id_ack
//   q_count : occupancy 0..DEPTH
module iop_queue #(
  parameter int ADDR_W    = 2,
  parameter int AFULL_LVL = 3
) (
  input  logic          clk,
  input  logic          a_rst_n,
  input  logic          flush,
  input  logic          dec_push,
  input  logic [31:0]   dec_iop,
  input  logic [2:0]    dec_init,
  input  logic [15:0]   dec_pc,
  input  logic [15:0]   dec_k16,
  output logic          dec_rdy,
  output logic          dec_afull,
  output logic          id_ack,
  output logic [31:0]   id_iop,
  output logic [2:0]    id_iop_init,
  output logic [15:0]   id_pc,
  output logic [15:0]   id_k16,
  input  logic          id_feed,
  output logic [ADDR_W:0] q_count
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
  logic [66:0]       mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr, wr_ptr;
  logic [ADDR_W:0]   count;
  logic [66:0]       din, head;
  logic              empty, byp, wr, rd;
  assign din   = {dec_iop, dec_init, dec_pc, dec_k16};
  assign empty = (count == '0);
`ifdef IOPQ_BYPASS_EN
  assign byp = empty & dec_push & ~flush;
`else
  assign byp = 1'b0;
`endif
  assign head      = byp ? din : empty ? '0 : mem[rd_ptr];
  assign {id_iop, id_iop_init, id_pc, id_k16} = head;
  assign id_ack    = ~flush & (~empty | byp);
  assign dec_rdy   = ~flush & (count != FULL_CNT);
  assign dec_afull = (count >= AFULL_CNT);
  assign q_count   = count;
  // A bypassed bundle consumed in the same cycle never touches storage.
  assign wr = dec_push & dec_rdy & ~(byp & id_feed);
  assign rd = id_feed & id_ack & ~byp;
  always_ff @(posedge clk or negedge a_rst_n)
    if (!a_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (ADDR_W+1)'(wr) - (ADDR_W+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: tb/tb_iop_queue.sv
// tb_iop_queue: directed and random checks of iop_queue against a queue-based model
module tb_iop_queue;
  localparam int DEPTH = 4;
`ifdef IOPQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, a_rst_n = 1'b0, flush = 1'b0, dec_push = 1'b0, id_feed = 1'b0;
  logic [31:0] dec_iop = '0;
  logic [2:0]  dec_init = '0;
  logic [15:0] dec_pc = '0, dec_k16 = '0;
  logic dec_rdy, dec_afull, id_ack;
  logic [31:0] id_iop;
  logic [2:0]  id_iop_init;
  logic [15:0] id_pc, id_k16;
  logic [2:0]  q_count;
  int errs = 0, checks = 0;
  logic [66:0] q[$];

  iop_queue #(.ADDR_W(2), .AFULL_LVL(3)) dut (
    .clk(clk), .a_rst_n(a_rst_n), .flush(flush), .dec_push(dec_push),
    .dec_iop(dec_iop), .dec_init(dec_init), .dec_pc(dec_pc), .dec_k16(dec_k16),
    .dec_rdy(dec_rdy), .dec_afull(dec_afull), .id_ack(id_ack), .id_iop(id_iop),
    .id_iop_init(id_iop_init), .id_pc(id_pc), .id_k16(id_k16), .id_feed(id_feed),
    .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [66:0] rnd_bundle();
    return {32'($urandom), 3'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  // One clock cycle: drive inputs, check combinational outputs against the model, advance the model.
  task automatic cyc(input bit p, input bit f, input bit fl, input logic [66:0] d, input string tag);
    int n;
    bit full, byp, ack, pushed, popped;
    logic [66:0] head;
    dec_push = p; id_feed = f; flush = fl;
    {dec_iop, dec_init, dec_pc, dec_k16} = d;
    n = q.size();
    full = (n == DEPTH);
    byp = BYP && n == 0 && p && !fl;
    ack = !fl && (n > 0 || byp);
    head = byp ? d : (n > 0 ? q[0] : 67'd0);
    #3;
    chk({tag, ".count"}, 67'(q_count), 67'(n));
    chk({tag, ".rdy"},   67'(dec_rdy), 67'(!full && !fl));
    chk({tag, ".afull"}, 67'(dec_afull), 67'(n >= 3));
    chk({tag, ".ack"},   67'(id_ack), 67'(ack));
    if (!fl) chk({tag, ".head"}, {id_iop, id_iop_init, id_pc, id_k16}, head);
    pushed = p && !full && !fl;
    popped = f && ack;
    if (fl) q.delete();
    else if (!(byp && f)) begin
      if (popped) void'(q.pop_front());
      if (pushed) q.push_back(d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst.count", 67'(q_count), 67'd0);
    chk("rst.ack", 67'(id_ack), 67'd0);
    chk("rst.rdy", 67'(dec_rdy), 67'd1);
    chk("rst.iop", 67'(id_iop), 67'd0);
    @(negedge clk) a_rst_n = 1'b1;
    @(posedge clk); #1;
    // Fill to full with 0x11..0x14, one ignored push while full, then drain in order.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, {32'h11 + 32'(i), 35'd0}, "fill");
    cyc(1, 0, 0, {32'h99, 35'd0}, "full_push");
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, '0, "drain");
    // Full with simultaneous pop: 0x55 must not be written.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, rnd_bundle(), "fill2");
    cyc(1, 1, 0, {32'h55, 35'd0}, "full_pop");
    cyc(0, 0, 0, '0, "after_full_pop");
    // Steady stream at count 2 with pointer wrap.
    cyc(0, 1, 0, '0, "to2");
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, rnd_bundle(), "stream");
    // Flush with concurrent push and pop at count 3.
    cyc(1, 0, 0, rnd_bundle(), "to3");
    cyc(1, 1, 1, rnd_bundle(), "flush");
    cyc(0, 0, 0, '0, "post_flush");
    // Empty queue push with station ready (bypass case when built with it).
    cyc(1, 1, 0, {32'hA5A5_0001, 35'd0}, "bypass");
    cyc(0, 0, 0, '0, "post_bypass");
    cyc(0, 1, 0, '0, "clear");
    // Random traffic.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0,
          rnd_bundle(), "rand");
    // Asynchronous reset in the middle of traffic at count 2.
    cyc(1, 1, 1, '0, "pre_rst_flush");
    cyc(1, 0, 0, rnd_bundle(), "pre_rst1");
    cyc(1, 0, 0, rnd_bundle(), "pre_rst2");
    dec_push = 1'b0; id_feed = 1'b0;
    #1;
    chk("pre_rst.count", 67'(q_count), 67'd2);
    a_rst_n = 1'b0;
    #1;
    chk("arst.count", 67'(q_count), 67'd0);
    chk("arst.ack", 67'(id_ack), 67'd0);
    chk("arst.rdy", 67'(dec_rdy), 67'd1);
    chk("arst.iop", 67'(id_iop), 67'd0);
    q.delete();
    @(negedge clk) a_rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 0, 0, rnd_bundle(), "post_rst");
    cyc(0, 1, 0, '0, "post_rst_pop");
    cyc(0, 0, 0, '0, "end");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
